// File: rtl/program_memory_pkg.sv
// Shared CPU definitions: program store geometry and the load FSM state type.
// Used by program_memory, ProgramCounter and ControlUnit.
package program_memory_pkg;

  localparam int PROG_ADDR_W = 8;
  localparam int PROG_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } prog_load_state_t;

endpackage

// File: rtl/program_memory_if.sv
// Fetch port plus program load port of the program store.
// master = CPU/loader side, slave = program_memory.
interface program_memory_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memVal;
  // Load handshake: a byte moves on every rising clk edge where loadValid && loadReady;
  // loadData is don't-care otherwise, and the source may hold loadValid low for any time.
  logic              loadStart;
  logic              loadValid;
  logic [DATA_W-1:0] loadData;
  logic              loadReady;
  logic              cpuHold;
  logic              loadDone;
  logic              loadErr;

  modport master (
    output memAddr, loadStart, loadValid, loadData,
    input  memVal, loadReady, cpuHold, loadDone, loadErr
  );

  modport slave (
    input  memAddr, loadStart, loadValid, loadData,
    output memVal, loadReady, cpuHold, loadDone, loadErr
  );

endinterface

// File: rtl/program_memory_array.sv
// Program store array: synchronous write, asynchronous read, no reset,
// so contents survive extRst and a RAM can be inferred.
module prog_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_memory.sv
// Program store with a valid/ready loader that holds the CPU in reset while loading.
// Optional checksum byte and sticky loadErr when PROG_MEM_CHECKSUM_EN is defined.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int DATA_W = PROG_DATA_W
) (
  input  logic              clk,
  input  logic              extRst,
  program_memory_if.slave   bus,
  output prog_load_state_t  o_state
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  prog_load_state_t  r_state;
  prog_load_state_t  w_next;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W-1:0] w_len_lo;
  logic [ADDR_W:0]   w_len;
  logic              w_xfer;
  logic              w_we;
  logic              w_ready;
  logic              w_hold;
  logic [DATA_W-1:0] w_rdata;

  // A length byte of 0 stands for the full depth, hence the extra counter bit.
  assign w_len_lo = ADDR_W'(bus.loadData);
  assign w_len    = (w_len_lo == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, w_len_lo};

  assign w_ready = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign w_hold  = (r_state != ST_IDLE);
  assign w_xfer  = bus.loadValid && w_ready;
  assign w_we    = w_xfer && (r_state == ST_DATA) && !r_wr_ptr[ADDR_W];

  assign bus.loadReady = w_ready;
  assign bus.cpuHold   = w_hold;
  assign bus.loadDone  = (r_state == ST_DONE);
  assign bus.memVal    = w_hold ? '0 : w_rdata;
  assign o_state       = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.loadStart) w_next = ST_LEN;
      ST_LEN:   if (w_xfer) w_next = ST_DATA;
      ST_DATA: begin
        if (w_xfer && (r_remaining == ONE)) begin
`ifdef PROG_MEM_CHECKSUM_EN
          w_next = ST_CHECK;
`else
          w_next = ST_DONE;
`endif
        end
      end
      ST_CHECK: if (w_xfer) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge extRst) begin
    if (extRst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_LEN && w_xfer) begin
        r_remaining <= w_len;
        r_wr_ptr    <= '0;
      end else if (w_we) begin
        r_wr_ptr    <= r_wr_ptr + ONE;
        r_remaining <= r_remaining - ONE;
      end
    end
  end

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              r_err;

  // The sum restarts with each length byte; loadErr lives until the next loadStart.
  always_ff @(posedge clk or posedge extRst) begin
    if (extRst) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.loadStart) r_err <= 1'b0;
      if (r_state == ST_LEN && w_xfer) r_sum <= '0;
      else if (w_we) r_sum <= r_sum + bus.loadData;
      if (r_state == ST_CHECK && w_xfer && (bus.loadData != r_sum)) r_err <= 1'b1;
    end
  end

  assign bus.loadErr = r_err;
`else
  assign bus.loadErr = 1'b0;
`endif

  prog_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (bus.loadData),
    .i_raddr (bus.memAddr),
    .o_rdata (w_rdata)
  );

endmodule

// File: doc/program_memory.md
# program_memory

Byte-wide program store that answers the CPU's instruction fetches: it takes the program counter's `memAddr` and returns `memVal`. A valid/ready load port with a small state machine writes a new program into the store. While a load is in progress the block holds the CPU in reset, so the processor only ever fetches from a completely written image.

## Interface
Parameters:
- `ADDR_W`, default 8: address width. Depth is 2^ADDR_W words.
- `DATA_W`, default 8: word width. Must equal the CPU instruction width.

Ports:
- `clk` in 1: clock. Rising edge active.
- `extRst` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `memAddr` in ADDR_W: fetch address, driven by the program counter.
- `memVal` out DATA_W: fetched word, returned to the control unit.
- `loadStart` in 1: single-cycle request to begin a load. Sampled only in IDLE.
- `loadValid` in 1: a byte is present on `loadData`.
- `loadData` in DATA_W: load stream byte.
- `loadReady` out 1: block accepts a byte this cycle.
- `cpuHold` out 1: OR'd into the CPU's external reset.
- `loadDone` out 1: one-cycle pulse when a load completes.
- `loadErr` out 1: sticky checksum failure flag. Tied to 0 without the macro.

## Operation
- Fetch path:
  - `memVal = mem[memAddr]`, combinational read, same cycle as `memAddr`.
  - While `cpuHold` = 1, `memVal` is forced to 0.
- Handshake: a transfer occurs on any rising edge where `loadValid && loadReady`. `loadData` is ignored otherwise.
- FSM states: IDLE, LEN, DATA, CHECK (macro only), DONE.
- IDLE:
  - `loadReady` = 0 and `cpuHold` = 0.
  - `loadStart` = 1 moves the FSM to LEN and clears `loadErr`.
- LEN:
  - `loadReady` = 1.
  - The first transferred byte is the length N, captured into `remaining`. N = 0 means 2^ADDR_W words.
  - The write pointer `wrPtr` is cleared to 0, then the FSM moves to DATA.
- DATA:
  - `loadReady` = 1.
  - Each transfer writes `mem[wrPtr] <= loadData`, increments `wrPtr` and decrements `remaining`.
  - The transfer that takes `remaining` from 1 to 0 exits to CHECK (macro defined) or DONE (macro undefined).
  - Words at addresses ≥ N keep their previous contents.
- CHECK:
  - `loadReady` = 1.
  - One transfer is consumed and compared with the running sum. A mismatch sets `loadErr`. The FSM then moves to DONE.
- DONE:
  - `loadDone` = 1 and `loadReady` = 0 for one cycle, then IDLE.
- `cpuHold` = 1 in every state except IDLE.
- `loadStart` outside IDLE is ignored. A load cannot be restarted mid-stream.
- Arithmetic:
  - `wrPtr` and `remaining` are ADDR_W+1 bits wide, so N = 256 does not alias to 0.
  - The checksum is a DATA_W-bit sum modulo 2^DATA_W.

## Timing
- Reset values: FSM = IDLE, `loadReady` = 0, `cpuHold` = 0, `loadDone` = 0, `loadErr` = 0, `wrPtr` = 0, `remaining` = 0.
- Memory array is not reset. Contents are retained across `extRst` and are undefined at power-up.
- Reset during a load aborts immediately and `cpuHold` drops asynchronously. Words already written stay written.
- Fetch latency is 0 cycles (combinational).
- A write becomes visible on `memVal` from the cycle after its transfer edge, once `cpuHold` has dropped.
- Throughput is one byte per cycle.
- A load of N data bytes takes the following cycles from the `loadStart` edge to the `loadDone` pulse, assuming `loadValid` stays high:
  - 1 (LEN) + N (DATA) + 1 (DONE) without the macro.
  - One more cycle with the macro (CHECK).
- `cpuHold` falls on the edge that leaves DONE. The CPU's reset then releases on its next `clk` edge, and the PC restarts at 0.
- `loadValid` may drop at any point. The FSM simply waits; there is no timeout.

## Configuration
- Macro `PROG_MEM_CHECKSUM_EN`.
- Defined:
  - A running sum of all DATA-state bytes is kept, reset in LEN.
  - The CHECK state exists, and `loadErr` is set on mismatch.
  - `loadErr` stays set until the next `loadStart` or reset.
  - `cpuHold` is still released on error; reacting to `loadErr` is a system-level decision.
- Undefined: no CHECK state, no sum register, and `loadErr` is tied to 0.

## Structure
- The shared CPU package holds:
  - the FSM state enum `prog_load_state_t`;
  - `PROG_ADDR_W` = 8 and `PROG_DATA_W` = 8, which `ProgramCounter` and `ControlUnit` also use.
- One sub-module, `prog_mem_array`: synchronous write and asynchronous read, no reset, so a RAM can be inferred.
- The FSM, counters and checksum live in `program_memory`.

## Test plan
- Fetch after reset: preload `mem[5]` = 8'h3C through the backdoor, assert and release `extRst`, drive `memAddr` = 5 → `memVal` = 8'h3C in the same cycle, and `cpuHold` = 0.
- Basic load (macro undefined): `loadStart`, then bytes 3, 8'hA1, 8'hB2, 8'hC3 back-to-back → `loadDone` 5 cycles after `loadStart`, and `mem[0..2]` = A1, B2, C3.
  - `memVal` reads 0 while `cpuHold` = 1.
  - `mem[3]` is unchanged.
- Stalled source: same load with `loadValid` low for 2 cycles between data bytes → `loadDone` is delayed by exactly 2 cycles, with no duplicated or skipped writes.
- Full-depth load: length byte 0 followed by 256 bytes = address index → `mem[255]` = 8'hFF, and `loadDone` after 258 cycles.
- Checksum (macro defined):
  - Load 2, 8'h10, 8'h20, then 8'h30 → `loadErr` = 0.
  - Repeat with final byte 8'h31 → `loadErr` = 1, `loadDone` still pulses, and `cpuHold` releases.
- Reset mid-load: assert `extRst` after 2 of 4 data bytes → `cpuHold` and `loadReady` drop in the same cycle.
  - The FSM is in IDLE, the first 2 words are written and the rest are unchanged.
  - `loadStart` during a load (no reset) is ignored.
